// File: rtl/watch_pkg.sv
// watch_pkg: shared states, cursor codes, BCD limits and hour-range helpers
package watch_pkg;
  typedef enum logic [2:0] {RUN, SET_H1, SET_H0, SET_M1, SET_M0} state_t;
  localparam logic [1:0] CUR_H1 = 2'd3, CUR_H0 = 2'd2, CUR_M1 = 2'd1, CUR_M0 = 2'd0;
  localparam logic [3:0] MAX_UNIT = 4'd9, MAX_TEN = 4'd5;
  localparam logic [3:0] MAX_H1_24 = 4'd2, MAX_H1_12 = 4'd1;
  localparam logic [3:0] MAX_H0_H2 = 4'd3, MAX_H0_12 = 4'd2;
  function automatic logic [3:0] h0_max(input logic h24, input logic [3:0] h1);
    return h24 ? (h1 == 4'd2 ? MAX_H0_H2 : MAX_UNIT) : (h1 == 4'd0 ? MAX_UNIT : MAX_H0_12);
  endfunction
  // 12h hours never show 00, so h0 starts at 1 while h1 is 0
  function automatic logic [3:0] h0_min(input logic h24, input logic [3:0] h1);
    return {3'b000, !h24 && h1 == 4'd0};
  endfunction
  function automatic logic [1:0] cursor_of(input state_t s);
    return s == SET_H1 ? CUR_H1 : s == SET_H0 ? CUR_H0 : s == SET_M1 ? CUR_M1 : CUR_M0;
  endfunction
  function automatic state_t next_digit(input state_t s);
    return s == SET_H1 ? SET_H0 : s == SET_H0 ? SET_M1 : s == SET_M1 ? SET_M0 : s == SET_M0 ? SET_H1 : RUN;
  endfunction
endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc: next value of one BCD digit, wrapping from max_val to min_val
// d/min_val/max_val: current digit and its legal range; en: step this cycle
// q: next digit value; carry: en while at max (wrap happened)
module bcd_digit_inc (
  input  logic [3:0] d,
  input  logic [3:0] min_val,
  input  logic [3:0] max_val,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = en & (d >= max_val);
  assign q = !en ? d : carry ? min_val : d + 4'd1;
endmodule

// File: rtl/watch_time_controller.sv
// watch_time_controller: hh:mm:ss timekeeping with button-driven digit editing
// clk/reset_n: clock and async active-low reset; tick_1hz: one-cycle second pulse
// btn_mode/btn_next/btn_up: debounced button levels
// h1..s0: BCD time digits; setting: in a SET state; cursor: edited digit; blank: blink mask
module watch_time_controller import watch_pkg::*; #(
  parameter bit HOUR24       = 1'b1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       setting,
  output logic [1:0] cursor,
  output logic [3:0] blank
);
  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [3:0] H1_MAX = HOUR24 ? MAX_H1_24 : MAX_H1_12;
  state_t state;
  logic mode_h, next_h, up_h, phase, run, tk, do_mode, do_next, do_up;
  logic [CW-1:0] cnt;
  logic [3:0] s0_n, s1_n, m0_n, m1_n, h0_n, h1_n, h0_lo, h0_fix;
  logic c_s0, c_s1, c_m0, c_m1, c_h0, day_wrap_unused;
  assign run     = state == RUN;
  assign do_mode = btn_mode & ~mode_h;
  assign do_next = btn_next & ~next_h & ~do_mode;
  assign do_up   = btn_up & ~up_h & ~do_mode & ~do_next;
  assign tk      = run & tick_1hz & ~do_mode;
  assign setting = ~run;
  assign cursor  = cursor_of(state);
  assign blank   = phase ? 4'b0001 << cursor : 4'b0000;
  // A counting wrap of h0 always toggles a 12h h1, so its restart value follows the new h1
  assign h0_lo = run ? h0_min(HOUR24, {3'b000, ~h1[0]}) : h0_min(HOUR24, h1);
  bcd_digit_inc u_s0 (.d(s0), .min_val(4'd0), .max_val(MAX_UNIT), .en(tk), .q(s0_n), .carry(c_s0));
  bcd_digit_inc u_s1 (.d(s1), .min_val(4'd0), .max_val(MAX_TEN), .en(c_s0), .q(s1_n), .carry(c_s1));
  bcd_digit_inc u_m0 (.d(m0), .min_val(4'd0), .max_val(MAX_UNIT),
    .en(c_s1 | (do_up && state == SET_M0)), .q(m0_n), .carry(c_m0));
  bcd_digit_inc u_m1 (.d(m1), .min_val(4'd0), .max_val(MAX_TEN),
    .en((c_m0 & tk) | (do_up && state == SET_M1)), .q(m1_n), .carry(c_m1));
  bcd_digit_inc u_h0 (.d(h0), .min_val(h0_lo), .max_val(h0_max(HOUR24, h1)),
    .en((c_m1 & tk) | (do_up && state == SET_H0)), .q(h0_n), .carry(c_h0));
  bcd_digit_inc u_h1 (.d(h1), .min_val(4'd0), .max_val(H1_MAX),
    .en((c_h0 & tk) | (do_up && state == SET_H1)), .q(h1_n), .carry(day_wrap_unused));
  // Editing h1 can leave h0 out of range for the new tens digit; snap it to the new minimum
  assign h0_fix = (do_up && state == SET_H1 &&
    (h0 > h0_max(HOUR24, h1_n) || h0 < h0_min(HOUR24, h1_n))) ? h0_min(HOUR24, h1_n) : h0_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      {mode_h, next_h, up_h} <= 3'b000;
      h1 <= HOUR24 ? 4'd0 : 4'd1;
      h0 <= HOUR24 ? 4'd0 : 4'd2;
      {m1, m0, s1, s0} <= 16'h0000;
      cnt <= '0;
      phase <= 1'b0;
    end else begin
      {mode_h, next_h, up_h} <= {btn_mode, btn_next, btn_up};
      h1 <= h1_n;
      h0 <= h0_fix;
      m1 <= m1_n;
      m0 <= m0_n;
      s1 <= (do_mode && !run) ? 4'd0 : s1_n;
      s0 <= (do_mode && !run) ? 4'd0 : s0_n;
      state <= do_mode ? (run ? SET_H1 : RUN) : do_next ? next_digit(state) : state;
      if (run || do_mode || do_next) begin
        cnt <= '0;
        phase <= 1'b0;
      end else if (cnt == CW'(BLINK_CYCLES - 1)) begin
        cnt <= '0;
        phase <= ~phase;
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_watch_time_controller.sv
// tb_watch_time_controller: table-driven scoreboard bench for 24h and 12h controller instances
module tb_watch_time_controller;
  localparam logic [2:0] Z = 3'b000, U = 3'b001, N = 3'b010, M = 3'b100;
  typedef struct {bit sel; logic [2:0] b; logic tk; logic [34:0] e;} vec_t;
  typedef struct {bit sel; logic [34:0] e; int id;} sb_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, tk_a, tk_b, a_set, b_set;
  logic [2:0] btn_a, btn_b;
  logic [1:0] a_cur, b_cur;
  logic [3:0] a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, a_blk;
  logic [3:0] b_h1, b_h0, b_m1, b_m0, b_s1, b_s0, b_blk;
  logic [34:0] obs_a, obs_b;
  vec_t tbl[$];
  sb_t sbq[$];
  sb_t mon;
  int checks = 0, errors = 0, nstep = 0;
  int kb[2];
  watch_time_controller #(.HOUR24(1'b1), .BLINK_CYCLES(1000)) dut_a (
    .clk(clk), .reset_n(rst_a), .tick_1hz(tk_a), .btn_mode(btn_a[2]), .btn_next(btn_a[1]),
    .btn_up(btn_a[0]), .h1(a_h1), .h0(a_h0), .m1(a_m1), .m0(a_m0), .s1(a_s1), .s0(a_s0),
    .setting(a_set), .cursor(a_cur), .blank(a_blk));
  watch_time_controller #(.HOUR24(1'b0), .BLINK_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(rst_b), .tick_1hz(tk_b), .btn_mode(btn_b[2]), .btn_next(btn_b[1]),
    .btn_up(btn_b[0]), .h1(b_h1), .h0(b_h0), .m1(b_m1), .m0(b_m0), .s1(b_s1), .s0(b_s0),
    .setting(b_set), .cursor(b_cur), .blank(b_blk));
  assign obs_a = {a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, a_set, a_cur, a_blk};
  assign obs_b = {b_h1, b_h0, b_m1, b_m0, b_s1, b_s0, b_set, b_cur, b_blk};
  function automatic logic [34:0] ex(input logic [23:0] t, input logic st, input logic [1:0] cur, input logic [3:0] bl);
    return {t, st, cur, bl};
  endfunction
  task automatic check(input string nm, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got time=%h set=%b cur=%0d blank=%b, expected time=%h set=%b cur=%0d blank=%b",
        nm, got[34:11], got[10], got[9:8], got[7:4], exp[34:11], exp[10], exp[9:8], exp[7:4]);
    end
  endtask
  // table row; blank follows edges since the last blink restart (mode entry or next)
  task automatic add(input bit sel, input logic [2:0] b, input logic tk, input logic [23:0] t,
                     input logic st, input logic [1:0] cur, input bit rs);
    int bl;
    logic [3:0] blk;
    kb[sel] = rs ? 0 : kb[sel] + 1;
    bl = sel ? 4 : 1000;
    blk = (st && (kb[sel] / bl) % 2 == 1) ? 4'b0001 << cur : 4'b0000;
    tbl.push_back('{sel, b, tk, ex(t, st, cur, blk)});
  endtask
  task automatic step(input bit sel, input logic [2:0] b, input logic tk, input logic [34:0] e);
    @(negedge clk);
    btn_a = sel ? Z : b;
    tk_a = sel ? 1'b0 : tk;
    btn_b = sel ? b : Z;
    tk_b = sel ? tk : 1'b0;
    sbq.push_back('{sel, e, nstep});
    nstep++;
  endtask
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon = sbq.pop_front();
      check($sformatf("step%0d_dut%s", mon.id, mon.sel ? "b" : "a"), mon.sel ? obs_b : obs_a, mon.e);
    end
  end
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; btn_a = Z; btn_b = Z; tk_a = 1'b0; tk_b = 1'b0;
    kb[0] = 0; kb[1] = 0;
    // 24h instance: reset, tick, h1/h0 wrap, clamp, preload 23:59, frozen ticks, mode+up, rollover
    add(0, Z, 0, 24'h000000, 0, 0, 0);
    add(0, Z, 1, 24'h000001, 0, 0, 0);
    add(0, M, 1, 24'h000001, 1, 3, 1);
    add(0, Z, 0, 24'h000001, 1, 3, 0);
    for (int i = 1; i <= 3; i++) begin
      add(0, U, 0, {4'(i % 3), 20'h00001}, 1, 3, 0);
      add(0, Z, 0, {4'(i % 3), 20'h00001}, 1, 3, 0);
    end
    add(0, N, 0, 24'h000001, 1, 2, 1);
    add(0, Z, 0, 24'h000001, 1, 2, 0);
    for (int i = 1; i <= 17; i++) begin
      add(0, U, 0, {4'h0, 4'(i > 10 ? i - 10 : i % 10), 16'h0001}, 1, 2, 0);
      add(0, Z, 0, {4'h0, 4'(i > 10 ? i - 10 : i % 10), 16'h0001}, 1, 2, 0);
    end
    for (int i = 1; i >= 0; i--) begin
      add(0, N, 0, 24'h070001, 1, 2'(i), 1);
      add(0, Z, 0, 24'h070001, 1, 2'(i), 0);
    end
    add(0, N, 0, 24'h070001, 1, 3, 1);
    add(0, Z, 0, 24'h070001, 1, 3, 0);
    add(0, U, 0, 24'h170001, 1, 3, 0);
    add(0, Z, 0, 24'h170001, 1, 3, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, U, 0, {4'(i == 1 ? 0 : i == 2 ? 1 : 2), 20'h00001}, 1, 3, 0);
      add(0, Z, 0, {4'(i == 1 ? 0 : i == 2 ? 1 : 2), 20'h00001}, 1, 3, 0);
    end
    add(0, N, 0, 24'h200001, 1, 2, 1);
    add(0, Z, 0, 24'h200001, 1, 2, 0);
    for (int i = 1; i <= 3; i++) begin
      add(0, U, 0, {4'h2, 4'(i), 16'h0001}, 1, 2, 0);
      add(0, Z, 0, {4'h2, 4'(i), 16'h0001}, 1, 2, 0);
    end
    add(0, N, 0, 24'h230001, 1, 1, 1);
    add(0, Z, 0, 24'h230001, 1, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      add(0, U, 0, {8'h23, 4'(i), 12'h001}, 1, 1, 0);
      add(0, Z, 0, {8'h23, 4'(i), 12'h001}, 1, 1, 0);
    end
    add(0, N, 0, 24'h235001, 1, 0, 1);
    add(0, Z, 0, 24'h235001, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      add(0, U, 0, {12'h235, 4'(i), 8'h01}, 1, 0, 0);
      add(0, Z, 0, {12'h235, 4'(i), 8'h01}, 1, 0, 0);
    end
    for (int i = 0; i < 3; i++) add(0, Z, 1, 24'h235901, 1, 0, 0);
    add(0, M | U, 0, 24'h235900, 0, 0, 0);
    for (int i = 1; i <= 59; i++) add(0, Z, 1, {16'h2359, 4'(i / 10), 4'(i % 10)}, 0, 0, 0);
    add(0, Z, 1, 24'h000000, 0, 0, 0);
    add(0, Z, 1, 24'h000001, 0, 0, 0);
    // 12h instance: reset value, preload 12:59, wrap to 01:00, 12h h1 clamp both ways
    add(1, Z, 0, 24'h120000, 0, 0, 0);
    add(1, M, 0, 24'h120000, 1, 3, 1);
    add(1, Z, 0, 24'h120000, 1, 3, 0);
    add(1, N, 0, 24'h120000, 1, 2, 1);
    add(1, Z, 0, 24'h120000, 1, 2, 0);
    add(1, N, 0, 24'h120000, 1, 1, 1);
    add(1, Z, 0, 24'h120000, 1, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      add(1, U, 0, {8'h12, 4'(i), 12'h000}, 1, 1, 0);
      add(1, Z, 0, {8'h12, 4'(i), 12'h000}, 1, 1, 0);
    end
    add(1, N, 0, 24'h125000, 1, 0, 1);
    add(1, Z, 0, 24'h125000, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      add(1, U, 0, {12'h125, 4'(i), 8'h00}, 1, 0, 0);
      add(1, Z, 0, {12'h125, 4'(i), 8'h00}, 1, 0, 0);
    end
    add(1, M, 0, 24'h125900, 0, 0, 0);
    for (int i = 1; i <= 59; i++) add(1, Z, 1, {16'h1259, 4'(i / 10), 4'(i % 10)}, 0, 0, 0);
    add(1, Z, 1, 24'h010000, 0, 0, 0);
    add(1, M, 0, 24'h010000, 1, 3, 1);
    add(1, Z, 0, 24'h010000, 1, 3, 0);
    add(1, N, 0, 24'h010000, 1, 2, 1);
    add(1, Z, 0, 24'h010000, 1, 2, 0);
    for (int i = 2; i <= 5; i++) begin
      add(1, U, 0, {4'h0, 4'(i), 16'h0000}, 1, 2, 0);
      add(1, Z, 0, {4'h0, 4'(i), 16'h0000}, 1, 2, 0);
    end
    for (int i = 1; i >= 0; i--) begin
      add(1, N, 0, 24'h050000, 1, 2'(i), 1);
      add(1, Z, 0, 24'h050000, 1, 2'(i), 0);
    end
    add(1, N, 0, 24'h050000, 1, 3, 1);
    add(1, Z, 0, 24'h050000, 1, 3, 0);
    add(1, U, 0, 24'h100000, 1, 3, 0);
    add(1, Z, 0, 24'h100000, 1, 3, 0);
    add(1, U, 0, 24'h010000, 1, 3, 0);
    add(1, Z, 0, 24'h010000, 1, 3, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].sel, tbl[i].b, tbl[i].tk, tbl[i].e);
    // held up button yields a single increment
    step(0, M, 0, ex(24'h000001, 1, 3, 4'b0));
    step(0, Z, 0, ex(24'h000001, 1, 3, 4'b0));
    step(0, N, 0, ex(24'h000001, 1, 2, 4'b0));
    for (int i = 0; i < 20; i++) step(0, U, 0, ex(24'h010001, 1, 2, 4'b0));
    step(0, Z, 0, ex(24'h010001, 1, 2, 4'b0));
    // build 14:37 then reset while editing h0
    for (int i = 2; i <= 4; i++) begin
      step(0, U, 0, ex({4'h0, 4'(i), 16'h0001}, 1, 2, 4'b0));
      step(0, Z, 0, ex({4'h0, 4'(i), 16'h0001}, 1, 2, 4'b0));
    end
    step(0, N, 0, ex(24'h040001, 1, 1, 4'b0));
    step(0, Z, 0, ex(24'h040001, 1, 1, 4'b0));
    for (int i = 1; i <= 3; i++) begin
      step(0, U, 0, ex({8'h04, 4'(i), 12'h001}, 1, 1, 4'b0));
      step(0, Z, 0, ex({8'h04, 4'(i), 12'h001}, 1, 1, 4'b0));
    end
    step(0, N, 0, ex(24'h043001, 1, 0, 4'b0));
    step(0, Z, 0, ex(24'h043001, 1, 0, 4'b0));
    for (int i = 1; i <= 7; i++) begin
      step(0, U, 0, ex({12'h043, 4'(i), 8'h01}, 1, 0, 4'b0));
      step(0, Z, 0, ex({12'h043, 4'(i), 8'h01}, 1, 0, 4'b0));
    end
    step(0, N, 0, ex(24'h043701, 1, 3, 4'b0));
    step(0, Z, 0, ex(24'h043701, 1, 3, 4'b0));
    step(0, U, 0, ex(24'h143701, 1, 3, 4'b0));
    step(0, Z, 0, ex(24'h143701, 1, 3, 4'b0));
    step(0, N, 0, ex(24'h143701, 1, 2, 4'b0));
    step(0, Z, 0, ex(24'h143701, 1, 2, 4'b0));
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("async_reset_mid_edit", obs_a, ex(24'h000000, 0, 0, 4'b0));
    @(negedge clk);
    rst_a = 1'b1;
    step(0, Z, 0, ex(24'h000000, 0, 0, 4'b0));
    // blink on the 12h instance (4-cycle half period), ticks ignored while editing
    step(1, N, 0, ex(24'h010000, 1, 2, 4'b0));
    step(1, Z, 0, ex(24'h010000, 1, 2, 4'b0));
    step(1, N, 0, ex(24'h010000, 1, 1, 4'b0));
    for (int i = 1; i <= 10; i++)
      step(1, Z, 1, ex(24'h010000, 1, 1, (i >= 4 && i < 8) ? 4'b0010 : 4'b0000));
    step(1, N, 0, ex(24'h010000, 1, 0, 4'b0));
    for (int i = 1; i <= 5; i++)
      step(1, Z, 0, ex(24'h010000, 1, 0, (i >= 4) ? 4'b0001 : 4'b0000));
    @(negedge clk);
    btn_a = Z; btn_b = Z; tk_a = 1'b0; tk_b = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
